// File: rtl/snoop_trigger_unit_if.sv
// +------------------------------------------------------------------+
// | snoop_trigger_unit_if : observed ACE snoop address (AC) channel  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface snoop_trigger_unit_if #(
  parameter int C_ACE_ADDR_WIDTH = 44
) ();
  logic                        acvalid;
  logic                        acready;
  logic [3:0]                  acsnoop;
  logic [C_ACE_ADDR_WIDTH-1:0] acaddr;

  modport master (output acvalid, acready, acsnoop, acaddr);
  modport slave  (input  acvalid, acready, acsnoop, acaddr);
endinterface

`default_nettype wire

// File: rtl/snoop_trigger_unit.sv
// +------------------------------------------------------------------+
// | snoop_trigger_unit : AC snoop filter and devil-path trigger FSM  |
// | Rev 1.0 -- optional hit counter: `define SNOOP_HIT_COUNTER_EN    |
// +------------------------------------------------------------------+
`default_nettype none

module snoop_trigger_unit #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int HIT_CNT_WIDTH      = 32
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  snoop_trigger_unit_if.slave           ac,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
  input  logic                          i_end_passive,
  input  logic                          i_end_active,
  output logic                          o_trigger_passive_path,
  output logic                          o_trigger_active_path,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr_snapshot,
  output logic [3:0]                    o_acsnoop_snapshot,
  output logic [2:0]                    o_trig_state,
  output logic [HIT_CNT_WIDTH-1:0]      o_hit_count
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_ACE_ADDR_WIDTH;
  localparam int AEW = DW + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_FIRE_P = 3'd2,
    ST_WAIT_P = 3'd3,
    ST_FIRE_A = 3'd4,
    ST_WAIT_A = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic            start_q, start_d;
  logic            hit_q, hit_d;
  logic [AW-1:0]   cap_addr_q, cap_addr_d;
  logic [3:0]      cap_snoop_q, cap_snoop_d;
  logic [AW-1:0]   snap_addr_q, snap_addr_d;
  logic [3:0]      snap_snoop_q, snap_snoop_d;

  logic            ctrl_en;
  logic            ctrl_start;
  logic            ctrl_passive;
  logic            start_rise;
  logic            type_ok;
  logic            in_window;
  logic            hit_w;
  logic [AEW-1:0]  win_lo;
  logic [AEW-1:0]  win_hi;
  logic [AEW-1:0]  addr_ext;
  logic            addr_hi_zero;
  logic            unused_ctrl_bits;

  assign ctrl_en      = i_control_reg[0];
  assign ctrl_start   = i_control_reg[1];
  assign ctrl_passive = i_control_reg[2];
  assign start_rise   = ctrl_start & ~start_q;

  assign unused_ctrl_bits = ^{i_control_reg[DW-1:3], i_acsnoop_reg[30:4]};

  // Window end is formed one bit wider than the registers so base+size never wraps.
  assign win_lo = {1'b0, i_base_addr_reg};
  assign win_hi = win_lo + {1'b0, i_addr_size_reg};

  generate
    if (AW > DW) begin : g_addr_wide
      assign addr_ext     = {1'b0, ac.acaddr[DW-1:0]};
      assign addr_hi_zero = ~|ac.acaddr[AW-1:DW];
    end else begin : g_addr_narrow
      assign addr_ext     = AEW'(ac.acaddr);
      assign addr_hi_zero = 1'b1;
    end
  endgenerate

  assign type_ok   = i_acsnoop_reg[31] | (ac.acsnoop == i_acsnoop_reg[3:0]);
  assign in_window = addr_hi_zero
                   & (i_addr_size_reg != '0)
                   & (addr_ext >= win_lo)
                   & (addr_ext < win_hi);
  assign hit_w     = ac.acvalid & ac.acready & ctrl_passive & type_ok & in_window;

  // Only hits observed while armed reach the FSM; busy-time snoops are dropped.
  always_comb begin
    hit_d       = hit_w & (state_q == ST_ARMED);
    cap_addr_d  = cap_addr_q;
    cap_snoop_d = cap_snoop_q;
    start_d     = ctrl_start;
    if (hit_w) begin
      cap_addr_d  = ac.acaddr;
      cap_snoop_d = ac.acsnoop;
    end
  end

  always_comb begin
    state_d                = state_q;
    pending_d              = pending_q | start_rise;
    snap_addr_d            = snap_addr_q;
    snap_snoop_d           = snap_snoop_q;
    o_trigger_passive_path = 1'b0;
    o_trigger_active_path  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!ctrl_en) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end else if (hit_q) begin
          // Passive wins a tie; the pending active request waits its turn.
          state_d      = ST_FIRE_P;
          snap_addr_d  = cap_addr_q;
          snap_snoop_d = cap_snoop_q;
        end else if (pending_q) begin
          state_d = ST_FIRE_A;
        end
      end
      ST_FIRE_P: begin
        o_trigger_passive_path = 1'b1;
        state_d                = ST_WAIT_P;
      end
      ST_WAIT_P: begin
        if (i_end_passive) state_d = ctrl_en ? ST_ARMED : ST_IDLE;
      end
      ST_FIRE_A: begin
        o_trigger_active_path = 1'b1;
        pending_d             = 1'b0;
        state_d               = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        if (i_end_active) state_d = ctrl_en ? ST_ARMED : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      start_q      <= 1'b0;
      hit_q        <= 1'b0;
      cap_addr_q   <= '0;
      cap_snoop_q  <= '0;
      snap_addr_q  <= '0;
      snap_snoop_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      start_q      <= start_d;
      hit_q        <= hit_d;
      cap_addr_q   <= cap_addr_d;
      cap_snoop_q  <= cap_snoop_d;
      snap_addr_q  <= snap_addr_d;
      snap_snoop_q <= snap_snoop_d;
    end
  end

  assign o_acaddr_snapshot  = snap_addr_q;
  assign o_acsnoop_snapshot = snap_snoop_q;
  assign o_trig_state       = state_q;

`ifdef SNOOP_HIT_COUNTER_EN
  logic [HIT_CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic                     en_q, en_d;

  // Counts every qualified hit, busy or not; cleared on enable falling.
  always_comb begin
    en_d      = ctrl_en;
    hit_cnt_d = hit_cnt_q;
    if (en_q && !ctrl_en) begin
      hit_cnt_d = '0;
    end else if (hit_w && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + HIT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      hit_cnt_q <= '0;
      en_q      <= 1'b0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      en_q      <= en_d;
    end
  end

  assign o_hit_count = hit_cnt_q;
`else
  assign o_hit_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snoop_trigger_unit.sv
// +------------------------------------------------------------------+
// | tb_snoop_trigger_unit : scoreboard bench for snoop_trigger_unit  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_snoop_trigger_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl = '0;
  logic [31:0] snp_reg = '0;
  logic [31:0] base = '0;
  logic [31:0] size = '0;
  logic        end_p = 1'b0;
  logic        end_a = 1'b0;
  logic        trig_p;
  logic        trig_a;
  logic [43:0] snap_addr;
  logic [3:0]  snap_snoop;
  logic [2:0]  state;
  logic [31:0] hit_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          act;
    logic [43:0] addr;
    logic [3:0]  snp;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  snoop_trigger_unit_if #(.C_ACE_ADDR_WIDTH(44)) ac_if ();

  snoop_trigger_unit #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_ACE_ADDR_WIDTH  (44),
    .HIT_CNT_WIDTH     (32)
  ) dut (
    .ace_aclk              (clk),
    .ace_aresetn           (rst_n),
    .ac                    (ac_if),
    .i_control_reg         (ctrl),
    .i_acsnoop_reg         (snp_reg),
    .i_base_addr_reg       (base),
    .i_addr_size_reg       (size),
    .i_end_passive         (end_p),
    .i_end_active          (end_a),
    .o_trigger_passive_path(trig_p),
    .o_trigger_active_path (trig_a),
    .o_acaddr_snapshot     (snap_addr),
    .o_acsnoop_snapshot    (snap_snoop),
    .o_trig_state          (state),
    .o_hit_count           (hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every trigger pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (trig_p || trig_a)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_trigger: got p=%0b a=%0b expected no trigger", trig_p, trig_a);
      end else begin
        mon_e = exp_q.pop_front();
        chk("trig_kind", {62'd0, trig_a, trig_p}, mon_e.act ? 64'd2 : 64'd1);
        chk("snap_addr", 64'(snap_addr), 64'(mon_e.addr));
        chk("snap_snoop", 64'(snap_snoop), 64'(mon_e.snp));
        if (mon_e.cyc >= 0) chk("trig_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_trig(input bit act, input logic [43:0] a, input logic [3:0] s, input int c);
    exp_t e;
    e.act  = act;
    e.addr = a;
    e.snp  = s;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; the handshake is sampled on the next rising edge.
  task automatic snoop(input logic [43:0] a, input logic [3:0] s);
    ac_if.acvalid = 1'b1;
    ac_if.acready = 1'b1;
    ac_if.acaddr  = a;
    ac_if.acsnoop = s;
    @(negedge clk);
    ac_if.acvalid = 1'b0;
    ac_if.acready = 1'b0;
  endtask

  task automatic hit(input logic [43:0] a, input logic [3:0] s);
    expect_trig(1'b0, a, s, cyc + 2);
    snoop(a, s);
  endtask

  task automatic end_pulse(input bit act);
    if (act) end_a = 1'b1;
    else     end_p = 1'b1;
    @(negedge clk);
    end_a = 1'b0;
    end_p = 1'b0;
  endtask

  initial begin
    ac_if.acvalid = 1'b0;
    ac_if.acready = 1'b0;
    ac_if.acaddr  = '0;
    ac_if.acsnoop = '0;
    wait_cyc(3);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_triggers", {62'd0, trig_a, trig_p}, 64'd0);
    chk("reset_snapshot", 64'(snap_addr), 64'd0);
    chk("reset_hit_count", 64'(hit_count), 64'd0);
    rst_n = 1'b1;
    wait_cyc(1);

    ctrl = 32'h5; snp_reg = 32'h1; base = 32'h1000; size = 32'h40;
    wait_cyc(1);
    chk("armed_after_enable", 64'(state), 64'd1);

    // Basic window hit
    hit(44'h1020, 4'h1);
    wait_cyc(2);
    chk("wait_p_state", 64'(state), 64'd3);
    chk("wait_p_snapshot", 64'(snap_addr), 64'h1020);
    end_pulse(1'b0);
    chk("armed_after_end_p", 64'(state), 64'd1);

    // Window boundaries and type filter
    snoop(44'h1040, 4'h1);
    wait_cyc(3);
    hit(44'h1000, 4'h1);
    wait_cyc(2);
    end_pulse(1'b0);
    snoop(44'h1_0000_1000, 4'h1);
    snoop(44'h1020, 4'h2);
    wait_cyc(3);
    chk("no_hit_state", 64'(state), 64'd1);
    size = 32'h0;
    snoop(44'h1000, 4'h1);
    snoop(44'h0, 4'h1);
    wait_cyc(3);
    chk("size0_state", 64'(state), 64'd1);
    size = 32'h40;
    snp_reg = 32'h8000_0001;
    hit(44'h1010, 4'h7);
    wait_cyc(2);
    end_pulse(1'b0);
    snp_reg = 32'h1;

    // Busy blocking
    hit(44'h1020, 4'h1);
    wait_cyc(2);
    snoop(44'h1030, 4'h1);
    wait_cyc(2);
    chk("busy_state", 64'(state), 64'd3);
    chk("busy_snapshot", 64'(snap_addr), 64'h1020);
    end_pulse(1'b0);
    chk("busy_end_state", 64'(state), 64'd1);
    hit(44'h1030, 4'h1);
    wait_cyc(2);
    end_pulse(1'b0);

    // Start edge coincident with a hit: passive first, then one active pulse
    ctrl = 32'h7;
    hit(44'h1008, 4'h1);
    expect_trig(1'b1, 44'h1008, 4'h1, -1);
    wait_cyc(2);
    chk("prio_wait_p", 64'(state), 64'd3);
    end_pulse(1'b0);
    chk("prio_armed_pending", 64'(state), 64'd1);
    wait_cyc(1);
    chk("prio_fire_a", 64'(state), 64'd4);
    wait_cyc(1);
    chk("prio_wait_a", 64'(state), 64'd5);
    end_pulse(1'b1);
    wait_cyc(6);
    chk("held_start_no_retrigger", 64'(state), 64'd1);
    ctrl = 32'h5;
    wait_cyc(2);

    // Disable while waiting on the active devil
    ctrl = 32'h7;
    expect_trig(1'b1, 44'h1008, 4'h1, -1);
    wait_cyc(3);
    chk("dis_wait_a", 64'(state), 64'd5);
    ctrl = 32'h4;
    wait_cyc(2);
    chk("dis_still_wait_a", 64'(state), 64'd5);
    end_pulse(1'b1);
    chk("dis_idle", 64'(state), 64'd0);
    snoop(44'h1020, 4'h1);
    wait_cyc(3);
    chk("idle_ignores_hit", 64'(state), 64'd0);
`ifdef SNOOP_HIT_COUNTER_EN
    chk("hit_count_after_clear", 64'(hit_count), 64'd1);
`else
    chk("hit_count_tied_zero", 64'(hit_count), 64'd0);
`endif

    // Asynchronous reset during the passive trigger pulse
    snoop(44'h1010, 4'h1);
    ctrl = 32'h5;
    wait_cyc(1);
    chk("rearmed", 64'(state), 64'd1);
    hit(44'h1004, 4'h1);
    wait_cyc(1);
    chk("fire_p_state", 64'(state), 64'd2);
`ifdef SNOOP_HIT_COUNTER_EN
    chk("hit_count_before_reset", 64'(hit_count), 64'd3);
`else
    chk("hit_count_before_reset", 64'(hit_count), 64'd0);
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("rst_triggers", {62'd0, trig_a, trig_p}, 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_snapshot", {16'd0, snap_snoop, snap_addr}, 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("post_reset_armed", 64'(state), 64'd1);
    wait_cyc(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
